// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Controller state encoding and default 640x480 raster timing.
// Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } vgaState_t;

  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FP     = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BP     = 48;
  localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FP     = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BP     = 33;
  localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_div
// Description : Divides clkRef into a registered one-cycle pixel strobe.
// Revision    : 1.0  initial release
// ============================================================================
module clk_en_div
  import vga_timing_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clkRef,
  input  logic reset,
  input  logic run,
  output logic pixEn
);

  localparam int              c_DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_DW-1:0] c_LAST = c_DW'(DIV - 1);

  logic [c_DW-1:0] r_divCnt;
  logic            r_pixEn;

  // Strobe is set on the last count so it is high while the count reads zero.
  always_ff @(posedge clkRef) begin
    if (reset) begin
      r_divCnt <= '0;
      r_pixEn  <= 1'b0;
    end else if (run) begin
      if (r_divCnt == c_LAST) begin
        r_divCnt <= '0;
        r_pixEn  <= 1'b1;
      end else begin
        r_divCnt <= r_divCnt + c_DW'(1);
        r_pixEn  <= 1'b0;
      end
    end else begin
      r_pixEn <= 1'b0;
    end
  end

  assign pixEn = r_pixEn;

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : Downstream reset hold, pixel enable and VGA raster timing.
//               Optional frame counter when FRAME_COUNT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   DIV        = 2,
  parameter int   RST_CYCLES = 3,
  parameter int   H_ACTIVE   = c_H_ACTIVE,
  parameter int   H_FP       = c_H_FP,
  parameter int   H_SYNC     = c_H_SYNC,
  parameter int   H_BP       = c_H_BP,
  parameter int   V_ACTIVE   = c_V_ACTIVE,
  parameter int   V_FP       = c_V_FP,
  parameter int   V_SYNC     = c_V_SYNC,
  parameter int   V_BP       = c_V_BP,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   CW         = 10
) (
  input  logic          clkRef,
  input  logic          reset,
  input  logic          enable,
  output logic          rstOut,
  output logic          pixEn,
  output logic          hsync,
  output logic          vsync,
  output logic          videoOn,
  output logic [CW-1:0] pixelX,
  output logic [CW-1:0] pixelY,
  output logic          frameStart
`ifdef FRAME_COUNT_EN
  ,
  output logic [7:0]    frameCount
`endif
);

  localparam int c_hTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_vTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HCW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [c_HCW-1:0] c_holdLast = c_HCW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    c_hLast    = CW'(c_hTot - 1);
  localparam logic [CW-1:0]    c_vLast    = CW'(c_vTot - 1);
  localparam logic [CW-1:0]    c_hAct     = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    c_vAct     = CW'(V_ACTIVE);
  localparam logic [CW-1:0]    c_hSyncBeg = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]    c_hSyncEnd = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]    c_vSyncBeg = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]    c_vSyncEnd = CW'(V_ACTIVE + V_FP + V_SYNC);

  vgaState_t        r_state;
  vgaState_t        w_stateNext;
  logic [c_HCW-1:0] r_holdCnt;
  logic             w_holdDone;
  logic             w_run;
  logic             w_enterRun;
  logic             w_pixEn;
  logic             w_adv;
  logic             w_lineEnd;
  logic             w_frameEnd;
  logic [CW-1:0]    r_hCnt;
  logic [CW-1:0]    r_vCnt;
  logic             r_frameStart;
  logic             w_hSyncWin;
  logic             w_vSyncWin;

  assign w_holdDone = (r_holdCnt == c_holdLast);

  always_ff @(posedge clkRef) begin
    if (reset) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_run       = 1'b0;
    w_enterRun  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (w_holdDone) begin
          w_stateNext = ST_RUN;
          w_enterRun  = 1'b1;
        end
      end
      ST_RUN:  w_run = enable;
      default: w_stateNext = ST_HOLD;
    endcase
  end

  always_ff @(posedge clkRef) begin
    if (reset) begin
      r_holdCnt <= '0;
    end else if ((r_state == ST_HOLD) && !w_holdDone) begin
      r_holdCnt <= r_holdCnt + c_HCW'(1);
    end
  end

  clk_en_div #(
    .DIV (DIV)
  ) u_clkEnDiv (
    .clkRef (clkRef),
    .reset  (reset),
    .run    (w_run),
    .pixEn  (w_pixEn)
  );

  // The strobe is already low when disabled; gating on w_run keeps HOLD inert too.
  assign w_adv      = w_run & w_pixEn;
  assign w_lineEnd  = (r_hCnt == c_hLast);
  assign w_frameEnd = w_lineEnd && (r_vCnt == c_vLast);

  always_ff @(posedge clkRef) begin
    if (reset) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_adv) begin
      if (w_lineEnd) begin
        r_hCnt <= '0;
        r_vCnt <= (r_vCnt == c_vLast) ? '0 : r_vCnt + CW'(1);
      end else begin
        r_hCnt <= r_hCnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clkRef) begin
    if (reset) begin
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_enterRun | (w_adv & w_frameEnd);
    end
  end

`ifdef FRAME_COUNT_EN
  logic [7:0] r_frameCount;

  // Counts raster wraps only; the RUN-entry pulse is frame zero.
  always_ff @(posedge clkRef) begin
    if (reset) begin
      r_frameCount <= '0;
    end else if (w_adv && w_frameEnd) begin
      r_frameCount <= r_frameCount + 8'd1;
    end
  end

  assign frameCount = r_frameCount;
`endif

  assign w_hSyncWin = (r_hCnt >= c_hSyncBeg) && (r_hCnt < c_hSyncEnd);
  assign w_vSyncWin = (r_vCnt >= c_vSyncBeg) && (r_vCnt < c_vSyncEnd);

  assign rstOut     = (r_state == ST_HOLD);
  assign pixEn      = w_pixEn;
  assign hsync      = w_hSyncWin ? SYNC_POL : ~SYNC_POL;
  assign vsync      = w_vSyncWin ? SYNC_POL : ~SYNC_POL;
  assign videoOn    = (r_hCnt < c_hAct) && (r_vCnt < c_vAct);
  assign pixelX     = r_hCnt;
  assign pixelY     = r_vCnt;
  assign frameStart = r_frameStart;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// Bench for vga_timing_ctrl: small-raster DUT against a pixel-index model,
// plus a default-timing instance (decode) and a DIV=1 instance (strobe).
module tb_vga_timing_ctrl;

  localparam int HA = 5, HFP = 1, HS = 2, HB = 2, HT = HA + HFP + HS + HB;
  localparam int VA = 3, VFP = 1, VS = 1, VB = 1, VT = VA + VFP + VS + VB;
  localparam int DIVM = 2, RSTM = 3, FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset, enable, en1;
  int   tests = 0, fails = 0, cyc = 0;
  bit   chkOn = 1'b0;

  logic rstOut, pixEn, hsync, vsync, videoOn, frameStart;
  logic [9:0] pixelX, pixelY;
  logic rstOutD, pixEnD, hsyncD, vsyncD, videoOnD, frameStartD;
  logic [9:0] pixelXD, pixelYD;
  logic rstOut1, pixEn1, hsync1, vsync1, videoOn1, frameStart1;
  logic [9:0] pixelX1, pixelY1;
`ifdef FRAME_COUNT_EN
  logic [7:0] frameCount, frameCountD, frameCount1;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vga_timing_ctrl #(.DIV(DIVM), .RST_CYCLES(RSTM), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS),
    .H_BP(HB), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .CW(10)) dut (
    .clkRef(clk), .reset(reset), .enable(enable), .rstOut(rstOut), .pixEn(pixEn),
    .hsync(hsync), .vsync(vsync), .videoOn(videoOn), .pixelX(pixelX), .pixelY(pixelY),
    .frameStart(frameStart)
`ifdef FRAME_COUNT_EN
    , .frameCount(frameCount)
`endif
  );

  vga_timing_ctrl dutD (
    .clkRef(clk), .reset(reset), .enable(en1), .rstOut(rstOutD), .pixEn(pixEnD),
    .hsync(hsyncD), .vsync(vsyncD), .videoOn(videoOnD), .pixelX(pixelXD), .pixelY(pixelYD),
    .frameStart(frameStartD)
`ifdef FRAME_COUNT_EN
    , .frameCount(frameCountD)
`endif
  );

  vga_timing_ctrl #(.DIV(1), .RST_CYCLES(RSTM), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS),
    .H_BP(HB), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)) dut1 (
    .clkRef(clk), .reset(reset), .enable(en1), .rstOut(rstOut1), .pixEn(pixEn1),
    .hsync(hsync1), .vsync(vsync1), .videoOn(videoOn1), .pixelX(pixelX1), .pixelY(pixelY1),
    .frameStart(frameStart1)
`ifdef FRAME_COUNT_EN
    , .frameCount(frameCount1)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: position is the number of pixel strobes consumed since RUN entry.
  bit mRun = 0, mPix = 0, mFs = 0;
  int mHold = 0, mTicks = 0, mP = 0, mWraps = 0;

  always @(posedge clk) begin
    if (reset) begin
      mRun = 0; mPix = 0; mFs = 0; mHold = 0; mTicks = 0; mP = 0; mWraps = 0;
    end else if (!mRun) begin
      mPix = 0; mFs = 0;
      if (mHold == RSTM - 1) begin mRun = 1; mFs = 1; end
      else mHold++;
    end else if (enable) begin
      mFs = 0;
      if (mPix) begin
        mP++;
        if (mP % FRAME == 0) begin mFs = 1; mWraps++; end
      end
      mTicks++;
      mPix = (mTicks % DIVM == 0);
    end else begin
      mPix = 0; mFs = 0;
    end
  end

  int ex, ey, maxXD = 0, prevXD = 0, prevX1 = 0;
  bit sawWrapD = 0, prevRst1 = 1, prevPix1 = 0;

  always @(negedge clk) begin
    if (chkOn) begin
      ex = mP % HT;
      ey = (mP / HT) % VT;
      chk("rstOut", rstOut, !mRun);
      chk("pixEn", pixEn, mPix);
      chk("pixelX", pixelX, ex);
      chk("pixelY", pixelY, ey);
      chk("hsync", hsync, !(ex >= HA + HFP && ex < HA + HFP + HS));
      chk("vsync", vsync, !(ey >= VA + VFP && ey < VA + VFP + VS));
      chk("videoOn", videoOn, (ex < HA) && (ey < VA));
      chk("frameStart", frameStart, mFs);
`ifdef FRAME_COUNT_EN
      chk("frameCount", frameCount, mWraps % 256);
`endif
      chk("D_hsync", hsyncD, !(pixelXD >= 656 && pixelXD < 752));
      chk("D_vsync", vsyncD, !(pixelYD >= 490 && pixelYD < 492));
      chk("D_videoOn", videoOnD, (pixelXD < 640) && (pixelYD < 480));
      if (pixelXD > maxXD) maxXD = pixelXD;
      if (prevXD == 799 && pixelXD == 0) sawWrapD = 1;
      prevXD = pixelXD;
      chk("1_rstOut", rstOut1, !mRun);
      if (rstOut1) chk("1_pixEnHold", pixEn1, 0);
      else if (!prevRst1) chk("1_pixEnConst", pixEn1, 1);
      if (prevPix1 && !rstOut1) chk("1_pixelX", pixelX1, (prevX1 + 1) % HT);
      prevRst1 = rstOut1; prevPix1 = pixEn1; prevX1 = pixelX1;
    end
  end

  task automatic releaseHold();
    int n, m;
    n = 0; m = 0;
    reset = 1'b0;
    for (int k = 0; k < 20 && rstOut; k++) begin n++; @(negedge clk); end
    chk("holdLen", n, RSTM);
    chk("entryFrameStart", frameStart, 1);
    for (int k = 0; k < 20 && !pixEn; k++) begin m++; @(negedge clk); end
    chk("firstPixEnDelay", m, DIVM);
  endtask

  task automatic measureFrame();
    int t0, vis, vsl;
    bit got;
    got = 0; vis = 0; vsl = 0;
    for (int k = 0; k < 400 && !frameStart; k++) @(negedge clk);
    chk("frameStartSeen", frameStart, 1);
    t0 = cyc;
    for (int k = 0; k < 400; k++) begin
      if (pixEn && videoOn) vis++;
      if (pixEn && !vsync) vsl++;
      @(negedge clk);
      if (frameStart) begin got = 1; break; end
    end
    chk("framePeriodSeen", got, 1);
    chk("framePeriod", cyc - t0, DIVM * FRAME);
    chk("visiblePixels", vis, HA * VA);
    chk("vsyncPixels", vsl, VS * HT);
  endtask

  int sx, sy, shs, svs, svo;

  initial begin
    reset = 1'b1; enable = 1'b1; en1 = 1'b1;
    repeat (2) @(negedge clk);
    chkOn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rstOut", rstOut, 1);
    chk("rst_pixelX", pixelX, 0);
    chk("rst_videoOn", videoOn, 1);
    chk("rst_hsync", hsync, 1);
    chk("rst_frameStart", frameStart, 0);
    releaseHold();
    measureFrame();

    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 3) != 0);
    end
    enable = 1'b1;

    for (int k = 0; k < 400 && !(pixelX == HT - 1 && pixelY == VT - 1); k++) @(negedge clk);
    chk("reachCorner", (pixelX == HT - 1) && (pixelY == VT - 1), 1);
    enable = 1'b0;
    sx = pixelX; sy = pixelY; shs = hsync; svs = vsync; svo = videoOn;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("frz_pixelX", pixelX, sx);
      chk("frz_pixelY", pixelY, sy);
      chk("frz_hsync", hsync, shs);
      chk("frz_vsync", vsync, svs);
      chk("frz_videoOn", videoOn, svo);
      chk("frz_pixEn", pixEn, 0);
    end
    enable = 1'b1;
    for (int k = 0; k < 10 && !pixEn; k++) @(negedge clk);
    chk("frz_resumePix", pixEn, 1);
    @(negedge clk);
    chk("wrap_pixelX", pixelX, 0);
    chk("wrap_pixelY", pixelY, 0);
    chk("wrap_frameStart", frameStart, 1);

    for (int k = 0; k < 400 && !(pixelX == 6 && pixelY == 3); k++) @(negedge clk);
    chk("reachMid", (pixelX == 6) && (pixelY == 3), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_pixelX", pixelX, 0);
    chk("mid_pixelY", pixelY, 0);
    chk("mid_rstOut", rstOut, 1);
    releaseHold();
    measureFrame();

`ifdef FRAME_COUNT_EN
    for (int k = 0; k < 40000 && frameCount != 8'd255; k++) @(negedge clk);
    chk("fc_reach255", frameCount, 255);
    @(negedge clk);
    for (int k = 0; k < 400 && !frameStart; k++) @(negedge clk);
    chk("fc_wrapPulse", frameStart, 1);
    chk("fc_wrapZero", frameCount, 0);
`endif

    chk("D_maxX", maxXD, 799);
    chk("D_wrapSeen", sawWrapD, 1);
    chkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
